ahb_burst_addr_gen: RTL and testbench

Parametrised AHB master-side burst sequencer. It accepts one burst command at a time and drives the AHB address-phase signals (HADDR, HTRANS, HBURST, HSIZE, HWRITE) beat by beat. It supports all eight HBURST encodings, including wrapping, BUSY insertion, 1KB-boundary splitting of undefined-length INCR bursts, and the two-cycle ERROR abort. It sits between the master driver BFM/stimulus layer and the AHB interface, and uses the burst, transfer, size and response encodings of the global package.

---
 rtl/ahb_burst_addr_gen_if.sv | 39 +++
 rtl/ahb_burst_addr_gen.sv | 213 +++++++++++++++++++++
 tb/tb_ahb_burst_addr_gen.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_burst_addr_gen_if.sv
// Command and AHB address-phase bundle for ahb_burst_addr_gen.
// master is the sequencer side; slave is the stimulus/bus side.
interface ahb_burst_addr_gen_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [2:0]            cmd_burst;
    logic [2:0]            cmd_size;
    logic                  cmd_write;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic                  busy_req;
    logic                  HREADY;
    logic                  HRESP;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic [2:0]            HBURST;
    logic [2:0]            HSIZE;
    logic                  HWRITE;
    logic                  beat_acc;
    logic                  done;
    logic                  err;

    modport master (
        input  cmd_valid, cmd_addr, cmd_burst, cmd_size, cmd_write, cmd_len,
               busy_req, HREADY, HRESP,
        output cmd_ready, HADDR, HTRANS, HBURST, HSIZE, HWRITE,
               beat_acc, done, err
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_burst, cmd_size, cmd_write, cmd_len,
               busy_req, HREADY, HRESP,
        input  cmd_ready, HADDR, HTRANS, HBURST, HSIZE, HWRITE,
               beat_acc, done, err
    );
endinterface

// File: rtl/ahb_burst_addr_gen.sv
// AHB master-side burst sequencer: turns one burst command into registered
// address-phase beats, with wrapping, BUSY insertion, 1KB split and ERROR abort.
module ahb_burst_addr_gen #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input logic                  HCLK,
    input logic                  HRESET,
    ahb_burst_addr_gen_if.master bus
);
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    localparam logic [2:0] BURST_SINGLE = 3'b000;
    localparam logic [2:0] BURST_INCR   = 3'b001;
    localparam logic [2:0] BURST_WRAP4  = 3'b010;
    localparam logic [2:0] BURST_INCR4  = 3'b011;
    localparam logic [2:0] BURST_WRAP8  = 3'b100;
    localparam logic [2:0] BURST_INCR8  = 3'b101;
    localparam logic [2:0] BURST_WRAP16 = 3'b110;
    localparam logic [2:0] BURST_INCR16 = 3'b111;

    localparam logic [2:0] SIZE_BYTE  = 3'b000;
    localparam logic       RESP_ERROR = 1'b1;

    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));
    localparam int         CNT_W    = LEN_WIDTH + 5;
    localparam int         BYTES_W  = CNT_W + 8;
    localparam logic [BYTES_W:0] KB_LIMIT = (BYTES_W + 1)'(1024);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_LAST_DATA,
        ST_ERR_WAIT
    } state_t;

    state_t                state_q, state_n;
    logic [ADDR_WIDTH-1:0] haddr_q, haddr_n;
    logic [1:0]            htrans_q, htrans_n;
    logic [2:0]            hburst_q, hburst_n;
    logic [2:0]            hsize_q, hsize_n;
    logic                  hwrite_q, hwrite_n;
    logic                  beat_acc_q, beat_acc_n;
    logic                  done_q, done_n;
    logic                  err_q, err_n;
    logic [CNT_W-1:0]      cnt_q, cnt_n;
    logic [CNT_W-1:0]      beats_q, beats_n;
    logic [ADDR_WIDTH-1:0] mask_q, mask_n;
    logic [ADDR_WIDTH-1:0] step_q, step_n;

    logic [CNT_W-1:0]      cmd_beats;
    logic [ADDR_WIDTH-1:0] cmd_step;
    logic [BYTES_W-1:0]    cmd_bytes;
    logic                  cmd_wrap;
    logic                  cmd_fixed_incr;
    logic [ADDR_WIDTH-1:0] cmd_mask;
    logic [BYTES_W:0]      cmd_kb_end;
    logic                  cmd_illegal;

    logic [ADDR_WIDTH-1:0] addr_inc;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [1:0]            next_kind;
    logic [1:0]            held_kind;
    logic [CNT_W-1:0]      cnt_inc;
    logic                  addr_phase;

    always_comb begin
        cmd_beats = CNT_W'(1);
        case (bus.cmd_burst)
            BURST_SINGLE:              cmd_beats = CNT_W'(1);
            BURST_INCR:                cmd_beats = (bus.cmd_len == '0) ? CNT_W'(1) : CNT_W'(bus.cmd_len);
            BURST_WRAP4, BURST_INCR4:  cmd_beats = CNT_W'(4);
            BURST_WRAP8, BURST_INCR8:  cmd_beats = CNT_W'(8);
            BURST_WRAP16, BURST_INCR16: cmd_beats = CNT_W'(16);
            default:                   cmd_beats = CNT_W'(1);
        endcase
    end

    // Incrementing bursts use an all-ones mask so the wrap formula degenerates to addr + B.
    assign cmd_step       = ADDR_WIDTH'(1) << bus.cmd_size;
    assign cmd_bytes      = BYTES_W'(cmd_beats) << bus.cmd_size;
    assign cmd_wrap       = (bus.cmd_burst != BURST_SINGLE) && !bus.cmd_burst[0];
    assign cmd_fixed_incr = bus.cmd_burst[0] && (bus.cmd_burst != BURST_INCR);
    assign cmd_mask       = cmd_wrap ? (ADDR_WIDTH'(cmd_bytes) - ADDR_WIDTH'(1)) : '1;
    assign cmd_kb_end     = (BYTES_W + 1)'(bus.cmd_addr[9:0]) + (BYTES_W + 1)'(cmd_bytes);
    assign cmd_illegal    = (bus.cmd_size > MAX_SIZE)
                         || ((bus.cmd_addr & (cmd_step - ADDR_WIDTH'(1))) != '0)
                         || (cmd_fixed_incr && (cmd_kb_end > KB_LIMIT));

    assign addr_inc   = haddr_q + step_q;
    assign next_addr  = (haddr_q & ~mask_q) | (addr_inc & mask_q);
    assign next_kind  = ((hburst_q == BURST_INCR) && (next_addr[9:0] == '0)) ? TR_NONSEQ : TR_SEQ;
    assign held_kind  = ((hburst_q == BURST_INCR) && (haddr_q[9:0] == '0)) ? TR_NONSEQ : TR_SEQ;
    assign cnt_inc    = cnt_q + CNT_W'(1);
    assign addr_phase = bus.HREADY && ((htrans_q == TR_NONSEQ) || (htrans_q == TR_SEQ));

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= ST_IDLE;
            haddr_q    <= '0;
            htrans_q   <= TR_IDLE;
            hburst_q   <= BURST_SINGLE;
            hsize_q    <= SIZE_BYTE;
            hwrite_q   <= 1'b0;
            beat_acc_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            beats_q    <= '0;
            mask_q     <= '0;
            step_q     <= '0;
        end else begin
            state_q    <= state_n;
            haddr_q    <= haddr_n;
            htrans_q   <= htrans_n;
            hburst_q   <= hburst_n;
            hsize_q    <= hsize_n;
            hwrite_q   <= hwrite_n;
            beat_acc_q <= beat_acc_n;
            done_q     <= done_n;
            err_q      <= err_n;
            cnt_q      <= cnt_n;
            beats_q    <= beats_n;
            mask_q     <= mask_n;
            step_q     <= step_n;
        end
    end

    // Error checks come first in each bus state so HRESP overrides busy_req.
    always_comb begin
        state_n    = state_q;
        haddr_n    = haddr_q;
        htrans_n   = htrans_q;
        hburst_n   = hburst_q;
        hsize_n    = hsize_q;
        hwrite_n   = hwrite_q;
        beat_acc_n = 1'b0;
        done_n     = 1'b0;
        err_n      = 1'b0;
        cnt_n      = cnt_q;
        beats_n    = beats_q;
        mask_n     = mask_q;
        step_n     = step_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    if (cmd_illegal) begin
                        err_n = 1'b1;
                    end else begin
                        state_n  = ST_ACTIVE;
                        haddr_n  = bus.cmd_addr;
                        htrans_n = TR_NONSEQ;
                        hburst_n = bus.cmd_burst;
                        hsize_n  = bus.cmd_size;
                        hwrite_n = bus.cmd_write;
                        cnt_n    = '0;
                        beats_n  = cmd_beats;
                        mask_n   = cmd_mask;
                        step_n   = cmd_step;
                    end
                end
            end
            ST_ACTIVE: begin
                if ((bus.HRESP == RESP_ERROR) && !bus.HREADY) begin
                    htrans_n = TR_IDLE;
                    state_n  = ST_ERR_WAIT;
                end else if (addr_phase) begin
                    beat_acc_n = 1'b1;
                    cnt_n      = cnt_inc;
                    if (cnt_inc == beats_q) begin
                        htrans_n = TR_IDLE;
                        state_n  = ST_LAST_DATA;
                    end else begin
                        haddr_n  = next_addr;
                        htrans_n = bus.busy_req ? TR_BUSY : next_kind;
                    end
                end else if (bus.HREADY && (htrans_q == TR_BUSY) && !bus.busy_req) begin
                    htrans_n = held_kind;
                end
            end
            ST_LAST_DATA: begin
                if ((bus.HRESP == RESP_ERROR) && !bus.HREADY) begin
                    state_n = ST_ERR_WAIT;
                end else if (bus.HREADY && (bus.HRESP != RESP_ERROR)) begin
                    done_n  = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_ERR_WAIT: begin
                if (bus.HREADY && (bus.HRESP == RESP_ERROR)) begin
                    err_n   = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.HADDR     = haddr_q;
    assign bus.HTRANS    = htrans_q;
    assign bus.HBURST    = hburst_q;
    assign bus.HSIZE     = hsize_q;
    assign bus.HWRITE    = hwrite_q;
    assign bus.beat_acc  = beat_acc_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_ahb_burst_addr_gen.sv
// Directed bench for ahb_burst_addr_gen: inputs change 1ns after each rising
// edge, outputs are checked at that same point against hand-computed values.
module tb_ahb_burst_addr_gen;
    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NS   = 2'b10;
    localparam logic [1:0] T_SQ   = 2'b11;

    logic HCLK;
    logic HRESET;
    int   total = 0;
    int   bad   = 0;

    ahb_burst_addr_gen_if #(.ADDR_WIDTH(32), .LEN_WIDTH(8)) bus ();

    ahb_burst_addr_gen #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(8)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus.master)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic apply_stimulus(input logic [31:0] a, input logic [2:0] b, input logic [2:0] s,
                                  input logic w, input logic [7:0] l);
        bus.cmd_addr  = a;
        bus.cmd_burst = b;
        bus.cmd_size  = s;
        bus.cmd_write = w;
        bus.cmd_len   = l;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        tick();
        total++;
        if ({bus.HADDR, bus.HTRANS, bus.HBURST, bus.HSIZE, bus.HWRITE, bus.cmd_ready, bus.beat_acc, bus.done, bus.err}
            !== {32'h0, T_IDLE, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL reset_values: got addr=%h tr=%b ready=%b", bus.HADDR, bus.HTRANS, bus.cmd_ready);
        end
        HRESET = 1'b0;
        tick();
        total++;
        if ({bus.HTRANS, bus.cmd_ready, bus.done, bus.err} !== {T_IDLE, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL reset_idle: got tr=%b ready=%b want 00 1", bus.HTRANS, bus.cmd_ready);
        end
    endtask

    task automatic test_incr4();
        logic [1:0]  et[4] = '{T_NS, T_SQ, T_SQ, T_SQ};
        logic [31:0] ea[4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
        apply_stimulus(32'h100, 3'b011, 3'd2, 1'b1, 8'd0);
        total++;
        if ({bus.cmd_ready, bus.HBURST, bus.HSIZE, bus.HWRITE} !== {1'b0, 3'b011, 3'd2, 1'b1}) begin
            bad++;
            $display("[TB] FAIL incr4_ctrl: got ready=%b burst=%b size=%0d wr=%b", bus.cmd_ready, bus.HBURST, bus.HSIZE, bus.HWRITE);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({bus.HTRANS, bus.HADDR, bus.beat_acc} !== {et[i], ea[i], (i != 0)}) begin
                bad++;
                $display("[TB] FAIL incr4_beat%0d: got tr=%b addr=%h acc=%b want tr=%b addr=%h", i, bus.HTRANS, bus.HADDR, bus.beat_acc, et[i], ea[i]);
            end
            tick();
        end
        total++;
        if ({bus.HTRANS, bus.beat_acc, bus.done} !== {T_IDLE, 1'b1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL incr4_tail: got tr=%b acc=%b done=%b want 00 1 0", bus.HTRANS, bus.beat_acc, bus.done);
        end
        tick();
        total++;
        if ({bus.done, bus.beat_acc, bus.cmd_ready, bus.err} !== {1'b1, 1'b0, 1'b1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL incr4_done: got done=%b acc=%b ready=%b want 1 0 1", bus.done, bus.beat_acc, bus.cmd_ready);
        end
        tick();
        total++;
        if (bus.done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL incr4_done_pulse: got done=%b want 0", bus.done);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] a4[4] = '{32'h38, 32'h3C, 32'h30, 32'h34};
        logic [31:0] a8[8] = '{32'h0E, 32'h00, 32'h02, 32'h04, 32'h06, 32'h08, 32'h0A, 32'h0C};
        apply_stimulus(32'h38, 3'b010, 3'd2, 1'b0, 8'd0);
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({bus.HTRANS, bus.HADDR} !== {(i == 0) ? T_NS : T_SQ, a4[i]}) begin
                bad++;
                $display("[TB] FAIL wrap4_beat%0d: got tr=%b addr=%h want addr=%h", i, bus.HTRANS, bus.HADDR, a4[i]);
            end
            tick();
        end
        tick();
        total++;
        if ({bus.done, bus.HTRANS} !== {1'b1, T_IDLE}) begin
            bad++;
            $display("[TB] FAIL wrap4_done: got done=%b tr=%b want 1 00", bus.done, bus.HTRANS);
        end
        apply_stimulus(32'h0E, 3'b100, 3'd1, 1'b0, 8'd0);
        for (int i = 0; i < 8; i++) begin
            total++;
            if ({bus.HTRANS, bus.HADDR} !== {(i == 0) ? T_NS : T_SQ, a8[i]}) begin
                bad++;
                $display("[TB] FAIL wrap8_beat%0d: got tr=%b addr=%h want addr=%h", i, bus.HTRANS, bus.HADDR, a8[i]);
            end
            tick();
        end
        tick();
        total++;
        if (bus.done !== 1'b1) begin
            bad++;
            $display("[TB] FAIL wrap8_done: got done=%b want 1", bus.done);
        end
    endtask

    task automatic test_incr_1kb();
        logic [1:0]  et[4] = '{T_NS, T_SQ, T_NS, T_SQ};
        logic [31:0] ea[4] = '{32'h3F8, 32'h3FC, 32'h400, 32'h404};
        apply_stimulus(32'h3F8, 3'b001, 3'd2, 1'b1, 8'd4);
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({bus.HTRANS, bus.HADDR} !== {et[i], ea[i]}) begin
                bad++;
                $display("[TB] FAIL incr_1kb_beat%0d: got tr=%b addr=%h want tr=%b addr=%h", i, bus.HTRANS, bus.HADDR, et[i], ea[i]);
            end
            tick();
        end
        tick();
        total++;
        if (bus.done !== 1'b1) begin
            bad++;
            $display("[TB] FAIL incr_1kb_done: got done=%b want 1", bus.done);
        end
    endtask

    task automatic test_waits_busy();
        logic        rdy[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        bsy[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [1:0]  et[8]   = '{T_SQ, T_BUSY, T_SQ, T_SQ, T_SQ, T_SQ, T_IDLE, T_IDLE};
        logic [31:0] ea[8]   = '{32'h104, 32'h108, 32'h108, 32'h108, 32'h108, 32'h10C, 32'h10C, 32'h10C};
        logic        eacc[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic        edn[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int          acc_seen = 0;
        apply_stimulus(32'h100, 3'b011, 3'd2, 1'b0, 8'd0);
        for (int i = 0; i < 8; i++) begin
            bus.HREADY   = rdy[i];
            bus.busy_req = bsy[i];
            tick();
            if (bus.beat_acc === 1'b1) acc_seen++;
            total++;
            if ({bus.HTRANS, bus.HADDR, bus.beat_acc, bus.done} !== {et[i], ea[i], eacc[i], edn[i]}) begin
                bad++;
                $display("[TB] FAIL waits_busy_step%0d: got tr=%b addr=%h acc=%b done=%b want tr=%b addr=%h acc=%b done=%b",
                         i, bus.HTRANS, bus.HADDR, bus.beat_acc, bus.done, et[i], ea[i], eacc[i], edn[i]);
            end
        end
        bus.HREADY   = 1'b1;
        bus.busy_req = 1'b0;
        total++;
        if (acc_seen != 4) begin
            bad++;
            $display("[TB] FAIL waits_busy_acc_count: got %0d want 4", acc_seen);
        end
    endtask

    task automatic test_error();
        apply_stimulus(32'h200, 3'b101, 3'd2, 1'b1, 8'd0);
        tick();
        total++;
        if ({bus.HTRANS, bus.HADDR, bus.beat_acc} !== {T_SQ, 32'h204, 1'b1}) begin
            bad++;
            $display("[TB] FAIL error_beat1: got tr=%b addr=%h acc=%b want 11 204 1", bus.HTRANS, bus.HADDR, bus.beat_acc);
        end
        bus.HRESP    = 1'b1;
        bus.HREADY   = 1'b0;
        bus.busy_req = 1'b1;
        tick();
        total++;
        if ({bus.HTRANS, bus.beat_acc, bus.cmd_ready, bus.err} !== {T_IDLE, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL error_first_cycle: got tr=%b acc=%b ready=%b err=%b want 00 0 0 0", bus.HTRANS, bus.beat_acc, bus.cmd_ready, bus.err);
        end
        bus.HREADY   = 1'b1;
        bus.busy_req = 1'b0;
        tick();
        total++;
        if ({bus.HTRANS, bus.err, bus.done, bus.cmd_ready} !== {T_IDLE, 1'b1, 1'b0, 1'b1}) begin
            bad++;
            $display("[TB] FAIL error_second_cycle: got tr=%b err=%b done=%b ready=%b want 00 1 0 1", bus.HTRANS, bus.err, bus.done, bus.cmd_ready);
        end
        bus.HRESP = 1'b0;
        tick();
        total++;
        if ({bus.err, bus.done, bus.HTRANS} !== {1'b0, 1'b0, T_IDLE}) begin
            bad++;
            $display("[TB] FAIL error_after: got err=%b done=%b tr=%b want 0 0 00", bus.err, bus.done, bus.HTRANS);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] ia[3] = '{32'h0, 32'h3F0, 32'h102};
        logic [2:0]  ib[3] = '{3'b011, 3'b111, 3'b000};
        logic [2:0]  is[3] = '{3'd3, 3'd2, 3'd2};
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(ia[i], ib[i], is[i], 1'b0, 8'd0);
            total++;
            if ({bus.err, bus.HTRANS, bus.cmd_ready} !== {1'b1, T_IDLE, 1'b1}) begin
                bad++;
                $display("[TB] FAIL illegal%0d: got err=%b tr=%b ready=%b want 1 00 1", i, bus.err, bus.HTRANS, bus.cmd_ready);
            end
            tick();
            total++;
            if ({bus.err, bus.HTRANS} !== {1'b0, T_IDLE}) begin
                bad++;
                $display("[TB] FAIL illegal%0d_after: got err=%b tr=%b want 0 00", i, bus.err, bus.HTRANS);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        apply_stimulus(32'h3F0, 3'b011, 3'd2, 1'b1, 8'd0);
        total++;
        if ({bus.HTRANS, bus.HADDR, bus.err} !== {T_NS, 32'h3F0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL kb_edge_accept: got tr=%b addr=%h err=%b want 10 3f0 0", bus.HTRANS, bus.HADDR, bus.err);
        end
        tick();
        tick();
        total++;
        if ({bus.HTRANS, bus.HADDR} !== {T_SQ, 32'h3F8}) begin
            bad++;
            $display("[TB] FAIL mid_burst_beat3: got tr=%b addr=%h want 11 3f8", bus.HTRANS, bus.HADDR);
        end
        HRESET = 1'b1;
        tick();
        total++;
        if ({bus.HADDR, bus.HTRANS, bus.HBURST, bus.HSIZE, bus.HWRITE, bus.cmd_ready, bus.beat_acc, bus.done, bus.err}
            !== {32'h0, T_IDLE, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL mid_burst_reset: got addr=%h tr=%b burst=%b acc=%b done=%b err=%b",
                     bus.HADDR, bus.HTRANS, bus.HBURST, bus.beat_acc, bus.done, bus.err);
        end
        HRESET = 1'b0;
        tick();
        total++;
        if ({bus.HTRANS, bus.done, bus.err, bus.cmd_ready} !== {T_IDLE, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("[TB] FAIL mid_burst_after: got tr=%b done=%b err=%b ready=%b", bus.HTRANS, bus.done, bus.err, bus.cmd_ready);
        end
    endtask

    task automatic test_back_to_back();
        apply_stimulus(32'h44, 3'b000, 3'd2, 1'b1, 8'd0);
        total++;
        if ({bus.HTRANS, bus.HADDR, bus.HBURST, bus.HWRITE} !== {T_NS, 32'h44, 3'b000, 1'b1}) begin
            bad++;
            $display("[TB] FAIL b2b_single: got tr=%b addr=%h burst=%b wr=%b", bus.HTRANS, bus.HADDR, bus.HBURST, bus.HWRITE);
        end
        tick();
        total++;
        if ({bus.HTRANS, bus.beat_acc} !== {T_IDLE, 1'b1}) begin
            bad++;
            $display("[TB] FAIL b2b_single_acc: got tr=%b acc=%b want 00 1", bus.HTRANS, bus.beat_acc);
        end
        tick();
        total++;
        if (bus.done !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b2b_single_done: got done=%b want 1", bus.done);
        end
        apply_stimulus(32'h81, 3'b001, 3'd0, 1'b0, 8'd0);
        total++;
        if ({bus.HTRANS, bus.HADDR, bus.HBURST, bus.HSIZE, bus.HWRITE} !== {T_NS, 32'h81, 3'b001, 3'd0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL b2b_incr_len0: got tr=%b addr=%h burst=%b size=%0d", bus.HTRANS, bus.HADDR, bus.HBURST, bus.HSIZE);
        end
        tick();
        total++;
        if ({bus.HTRANS, bus.beat_acc} !== {T_IDLE, 1'b1}) begin
            bad++;
            $display("[TB] FAIL b2b_incr_len0_one_beat: got tr=%b acc=%b want 00 1", bus.HTRANS, bus.beat_acc);
        end
        tick();
        total++;
        if (bus.done !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b2b_incr_done: got done=%b want 1", bus.done);
        end
    endtask

    initial begin
        HRESET        = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_burst = 3'b000;
        bus.cmd_size  = 3'b000;
        bus.cmd_write = 1'b0;
        bus.cmd_len   = '0;
        bus.busy_req  = 1'b0;
        bus.HREADY    = 1'b1;
        bus.HRESP     = 1'b0;
        tick();
        test_reset();
        test_incr4();
        test_wrap();
        test_incr_1kb();
        test_waits_busy();
        test_error();
        test_illegal();
        test_reset_mid_burst();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
